// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the packet receive front end: packet type codes,
// header byte offsets and the parser FSM state encoding.
package pkt_rx_pkg;

    typedef enum logic [2:0] {
        PKT_HEARTBEAT = 3'b000,
        PKT_DATA      = 3'b001,
        PKT_ACK       = 3'b010,
        PKT_ROUTE     = 3'b011,
        PKT_CMD       = 3'b100,
        PKT_ENERGY    = 3'b101,
        PKT_SYNC      = 3'b110,
        PKT_RESERVED  = 3'b111
    } pkt_type_e;

    // Offsets of the header bytes that follow TYPE, as seen by the header counter.
    localparam logic [2:0] HDR_SRC_H = 3'd0;
    localparam logic [2:0] HDR_SRC_L = 3'd1;
    localparam logic [2:0] HDR_DST_H = 3'd2;
    localparam logic [2:0] HDR_DST_L = 3'd3;
    localparam logic [2:0] HDR_EN_H  = 3'd4;
    localparam logic [2:0] HDR_EN_L  = 3'd5;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StLen,
        StPayload,
        StChk,
        StDone
    } state_e;

endpackage

// File: rtl/pkt_rx_parser_if.sv
// Byte stream, parsed field set and payload memory write port of the parser.
// master: stream source / consumer side, slave: the parser itself.
interface pkt_rx_if #(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = 8,
    parameter int unsigned WW = 16
) ();
    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_ready;
    logic [2:0]    fPktType;
    logic [WW-1:0] sourceID;
    logic [WW-1:0] destinationID;
    logic [WW-1:0] energyLvl;
    logic [7:0]    pktLen;
    logic          newpkt;
    logic          pkt_err;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, fPktType, sourceID, destinationID, energyLvl, pktLen,
        input  newpkt, pkt_err, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, fPktType, sourceID, destinationID, energyLvl, pktLen,
        output newpkt, pkt_err, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pkt_xor_chk.sv
// Running XOR over frame bytes with clear, accumulate and compare-against-input.
// clr_i and acc_i together load the current byte as the first term.
module pkt_xor_chk #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr_i,
    input  logic         acc_i,
    input  logic [W-1:0] data_i,
    output logic         match_o
);
    logic [W-1:0] sum_q, sum_d;

    // Next running XOR value.
    always_comb begin
        sum_d = clr_i ? '0 : sum_q;
        if (acc_i) begin
            sum_d = sum_d ^ data_i;
        end
    end

    // Running XOR register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_o = (sum_q == data_i);
endmodule

// File: rtl/pkt_rx_parser.sv
// Byte-serial receive parser: collects header fields into shadow registers, writes
// payload bytes to packet memory and announces each good packet with newpkt.
// Build option: define PKT_CHECKSUM_EN to expect a trailing XOR checksum byte.
module pkt_rx_parser
    import pkt_rx_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 2048,
    parameter int unsigned MEM_WIDTH   = 8,
    parameter int unsigned WORD_WIDTH  = 16,
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned BASE_ADDR   = 0
) (
    input logic     clk,
    input logic     nrst,
    pkt_rx_if.slave bus
);
    localparam int unsigned    AW       = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0]  BaseAddr = AW'(BASE_ADDR % MEM_DEPTH);
    localparam logic [7:0]     MaxLen   = 8'(MAX_PAYLOAD);

    state_e                  state_q, state_d;
    logic [2:0]              hdr_cnt_q, hdr_cnt_d;
    logic [7:0]              pay_cnt_q, pay_cnt_d;
    logic                    drop_q, drop_d;
    logic [2:0]              sh_type_q, sh_type_d;
    logic [WORD_WIDTH-1:0]   sh_src_q, sh_src_d, sh_dst_q, sh_dst_d, sh_en_q, sh_en_d;
    logic [7:0]              sh_len_q, sh_len_d;
    logic [2:0]              fld_type_q, fld_type_d;
    logic [WORD_WIDTH-1:0]   fld_src_q, fld_src_d, fld_dst_q, fld_dst_d, fld_en_q, fld_en_d;
    logic [7:0]              fld_len_q, fld_len_d;
    logic                    newpkt_q, newpkt_d, pkt_err_q, pkt_err_d, mem_we_q, mem_we_d;
    logic [AW-1:0]           mem_addr_q, mem_addr_d;
    logic [MEM_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic                    rx_ready, accept, body_end, frame_end;
    logic [MEM_WIDTH-1:0]    rx_byte;

    assign rx_ready = (state_q != StDone);
    assign accept   = bus.rx_valid && rx_ready;
    assign rx_byte  = bus.rx_data;

`ifdef PKT_CHECKSUM_EN
    logic chk_clr, chk_acc, chk_match;

    // Every accepted byte before CHK feeds the XOR; TYPE restarts it.
    assign chk_clr = accept && (state_q == StIdle);
    assign chk_acc = accept && (state_q inside {StIdle, StHdr, StLen, StPayload});

    pkt_xor_chk #(
        .W (MEM_WIDTH)
    ) u_chk (
        .clk     (clk),
        .nrst    (nrst),
        .clr_i   (chk_clr),
        .acc_i   (chk_acc),
        .data_i  (rx_byte),
        .match_o (chk_match)
    );
`endif

    // Next-state, shadow capture, payload write and end-of-frame announcement.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        drop_d      = drop_q;
        sh_type_d   = sh_type_q;
        sh_src_d    = sh_src_q;
        sh_dst_d    = sh_dst_q;
        sh_en_d     = sh_en_q;
        sh_len_d    = sh_len_q;
        fld_type_d  = fld_type_q;
        fld_src_d   = fld_src_q;
        fld_dst_d   = fld_dst_q;
        fld_en_d    = fld_en_q;
        fld_len_d   = fld_len_q;
        newpkt_d    = 1'b0;
        pkt_err_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        body_end    = 1'b0;
        frame_end   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sh_type_d = rx_byte[2:0];
                    drop_d    = (rx_byte[2:0] == PKT_RESERVED);
                    hdr_cnt_d = '0;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    case (hdr_cnt_q)
                        HDR_SRC_H, HDR_SRC_L:
                            sh_src_d = {sh_src_q[WORD_WIDTH-MEM_WIDTH-1:0], rx_byte};
                        HDR_DST_H, HDR_DST_L:
                            sh_dst_d = {sh_dst_q[WORD_WIDTH-MEM_WIDTH-1:0], rx_byte};
                        default:
                            sh_en_d  = {sh_en_q[WORD_WIDTH-MEM_WIDTH-1:0], rx_byte};
                    endcase
                    if (hdr_cnt_q == HDR_EN_L) begin
                        state_d = StLen;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 3'd1;
                    end
                end
            end
            StLen: begin
                if (accept) begin
                    sh_len_d  = 8'(rx_byte);
                    pay_cnt_d = '0;
                    if (8'(rx_byte) > MaxLen) begin
                        drop_d = 1'b1;
                    end
                    if (8'(rx_byte) == 8'd0) begin
                        body_end = 1'b1;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    // Dropped frames are still consumed by length, just never written.
                    if (!drop_q) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BaseAddr + AW'(pay_cnt_q);
                        mem_wdata_d = rx_byte;
                    end
                    if (pay_cnt_q == sh_len_q - 8'd1) begin
                        body_end = 1'b1;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 8'd1;
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            StChk: begin
                if (accept) begin
                    if (!chk_match) begin
                        drop_d = 1'b1;
                    end
                    frame_end = 1'b1;
                end
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (body_end) begin
`ifdef PKT_CHECKSUM_EN
            state_d = StChk;
`else
            frame_end = 1'b1;
`endif
        end

        // Fields and strobe are registered together so both appear in the DONE cycle.
        if (frame_end) begin
            state_d = StDone;
            if (drop_d) begin
                pkt_err_d = 1'b1;
            end else begin
                newpkt_d   = 1'b1;
                fld_type_d = sh_type_d;
                fld_src_d  = sh_src_d;
                fld_dst_d  = sh_dst_d;
                fld_en_d   = sh_en_d;
                fld_len_d  = sh_len_d;
            end
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StIdle;
            hdr_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            drop_q      <= 1'b0;
            sh_type_q   <= PKT_RESERVED;
            sh_src_q    <= '0;
            sh_dst_q    <= '0;
            sh_en_q     <= '0;
            sh_len_q    <= '0;
            fld_type_q  <= PKT_RESERVED;
            fld_src_q   <= '0;
            fld_dst_q   <= '0;
            fld_en_q    <= '0;
            fld_len_q   <= '0;
            newpkt_q    <= 1'b0;
            pkt_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BaseAddr;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            drop_q      <= drop_d;
            sh_type_q   <= sh_type_d;
            sh_src_q    <= sh_src_d;
            sh_dst_q    <= sh_dst_d;
            sh_en_q     <= sh_en_d;
            sh_len_q    <= sh_len_d;
            fld_type_q  <= fld_type_d;
            fld_src_q   <= fld_src_d;
            fld_dst_q   <= fld_dst_d;
            fld_en_q    <= fld_en_d;
            fld_len_q   <= fld_len_d;
            newpkt_q    <= newpkt_d;
            pkt_err_q   <= pkt_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.rx_ready      = rx_ready;
    assign bus.fPktType      = fld_type_q;
    assign bus.sourceID      = fld_src_q;
    assign bus.destinationID = fld_dst_q;
    assign bus.energyLvl     = fld_en_q;
    assign bus.pktLen        = fld_len_q;
    assign bus.newpkt        = newpkt_q;
    assign bus.pkt_err       = pkt_err_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_pkt_rx_parser.sv
// Randomised scoreboard bench for pkt_rx_parser; the reference model derives every
// expected write and announcement directly from the frame byte list.
module tb_pkt_rx_parser;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned AW    = 11;
    localparam int unsigned BASE  = 2046;
    localparam int unsigned MAXP  = 64;
    localparam int          HALF  = 5;

    typedef struct {
        bit          is_err;
        logic [2:0]  t;
        logic [15:0] s;
        logic [15:0] d;
        logic [15:0] e;
        logic [7:0]  l;
    } ev_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    time  last_acc = 0;

    ev_t        evq[$];
    wr_t        wrq[$];
    logic [7:0] fr[$];

    logic [2:0]  hold_t = 3'b111;
    logic [15:0] hold_s = '0, hold_d = '0, hold_e = '0;
    logic [7:0]  hold_l = '0;

    pkt_rx_if #(.AW(AW), .DW(8), .WW(16)) bus ();

    pkt_rx_parser #(
        .MEM_DEPTH   (DEPTH),
        .MEM_WIDTH   (8),
        .WORD_WIDTH  (16),
        .MAX_PAYLOAD (MAXP),
        .BASE_ADDR   (BASE)
    ) u_dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #HALF clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame byte list: TYPE, SRC, DST, EN, LEN, random payload [, CHK].
    task automatic build(input logic [7:0] tb_, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] e, input logic [7:0] len, input bit bad_chk);
        logic [7:0] x;
        fr = {};
        fr.push_back(tb_);
        fr.push_back(s[15:8]); fr.push_back(s[7:0]);
        fr.push_back(d[15:8]); fr.push_back(d[7:0]);
        fr.push_back(e[15:8]); fr.push_back(e[7:0]);
        fr.push_back(len);
        for (int k = 0; k < int'(len); k++) fr.push_back(8'($urandom));
        x = 8'h00;
        foreach (fr[i]) x = x ^ fr[i];
`ifdef PKT_CHECKSUM_EN
        fr.push_back(bad_chk ? (x ^ 8'h01) : x);
`else
        if (bad_chk && x == 8'h5a) x = 8'h00;
`endif
    endtask

    // Reference model: outcome and memory writes of the frame in fr.
    task automatic model();
        ev_t        ev;
        logic [7:0] x, b0, len;
        bit         bad;
        int         n;
        n   = 8;
        b0  = fr[0];
        len = fr[7];
        bad = 1'b0;
`ifdef PKT_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
        bad = (x != fr[fr.size() - 1]);
`else
        x = 8'h00;
`endif
        ev.t = b0[2:0];
        ev.s = {fr[1], fr[2]};
        ev.d = {fr[3], fr[4]};
        ev.e = {fr[5], fr[6]};
        ev.l = len;
        ev.is_err = (ev.t == 3'b111) || (int'(len) > MAXP) || bad;
        if (ev.t != 3'b111 && int'(len) <= MAXP) begin
            for (int k = 0; k < int'(len); k++) begin
                wr_t w;
                w.a = AW'((BASE + k) % DEPTH);
                w.d = fr[n + k];
                wrq.push_back(w);
            end
        end
        evq.push_back(ev);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        bit rdy, done;
        int tries;
        done  = 1'b0;
        tries = 0;
        if (gap) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            @(posedge clk);
        end
        while (!done) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = b;
            rdy = bus.rx_ready;
            @(posedge clk);
            if (rdy) begin
                done     = 1'b1;
                last_acc = $time;
            end else begin
                tries++;
                if (tries > 4) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_ready_stuck: got 0 expected 1 within 4 cycles");
                    done = 1'b1;
                end
            end
        end
    endtask

    // gap_mode: 0 none, 1 every other cycle, 2 random.
    task automatic send_frame(input int gap_mode);
        bit g;
        model();
        foreach (fr[i]) begin
            g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
            send_byte(fr[i], g);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_type"}, 32'(bus.fPktType), 32'h7);
        chk({tag, "_src"}, 32'(bus.sourceID), 32'h0);
        chk({tag, "_dst"}, 32'(bus.destinationID), 32'h0);
        chk({tag, "_en"}, 32'(bus.energyLvl), 32'h0);
        chk({tag, "_len"}, 32'(bus.pktLen), 32'h0);
        chk({tag, "_strobes"}, 32'({bus.newpkt, bus.pkt_err, bus.mem_we}), 32'h0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'(BASE));
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'h0);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'h1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes memory or strobes.
    ev_t m_ev;
    wr_t m_wr;
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.mem_we) begin
                checks++;
                if (wrq.size() == 0) begin
                    failures++;
                    $display("FAIL mem_write: got unexpected write addr %0d data %0h",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    m_wr = wrq.pop_front();
                    if (bus.mem_addr !== m_wr.a || bus.mem_wdata !== m_wr.d ||
                        $time != last_acc + HALF) begin
                        failures++;
                        $display("FAIL mem_write: got addr %0d data %0h expected addr %0d data %0h",
                                 bus.mem_addr, bus.mem_wdata, m_wr.a, m_wr.d);
                    end
                end
            end
            if (bus.newpkt || bus.pkt_err) begin
                checks++;
                if (evq.size() == 0) begin
                    failures++;
                    $display("FAIL announce: got newpkt=%0b pkt_err=%0b expected none",
                             bus.newpkt, bus.pkt_err);
                end else begin
                    m_ev = evq.pop_front();
                    if (bus.newpkt !== !m_ev.is_err || bus.pkt_err !== m_ev.is_err ||
                        $time != last_acc + HALF ||
                        (!m_ev.is_err && (bus.fPktType !== m_ev.t || bus.sourceID !== m_ev.s ||
                         bus.destinationID !== m_ev.d || bus.energyLvl !== m_ev.e ||
                         bus.pktLen !== m_ev.l))) begin
                        failures++;
                        $display("FAIL announce: got new=%0b err=%0b t=%0h s=%0h d=%0h e=%0h l=%0d expected err=%0b t=%0h s=%0h d=%0h e=%0h l=%0d",
                                 bus.newpkt, bus.pkt_err, bus.fPktType, bus.sourceID,
                                 bus.destinationID, bus.energyLvl, bus.pktLen, m_ev.is_err,
                                 m_ev.t, m_ev.s, m_ev.d, m_ev.e, m_ev.l);
                    end
                    if (!m_ev.is_err) begin
                        hold_t = m_ev.t; hold_s = m_ev.s; hold_d = m_ev.d;
                        hold_e = m_ev.e; hold_l = m_ev.l;
                    end
                end
            end
            if (!bus.newpkt) begin
                checks++;
                if (bus.fPktType !== hold_t || bus.sourceID !== hold_s ||
                    bus.destinationID !== hold_d || bus.energyLvl !== hold_e ||
                    bus.pktLen !== hold_l) begin
                    failures++;
                    $display("FAIL field_hold: got t=%0h s=%0h d=%0h e=%0h l=%0d expected t=%0h s=%0h d=%0h e=%0h l=%0d",
                             bus.fPktType, bus.sourceID, bus.destinationID, bus.energyLvl,
                             bus.pktLen, hold_t, hold_s, hold_d, hold_e, hold_l);
                end
            end
        end
    end

    initial begin
        logic [7:0] tb_, len;
        int r;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst0");
        nrst = 1'b1;

        // Heartbeat with LEN=0.
        build(8'h00, 16'h0003, 16'h0000, 16'h00FF, 8'd0, 1'b0);
        send_frame(0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("hb_newpkt", 32'(bus.newpkt), 32'h1);
        chk("hb_type", 32'(bus.fPktType), 32'h0);
        chk("hb_src", 32'(bus.sourceID), 32'h0003);
        chk("hb_dst", 32'(bus.destinationID), 32'h0000);
        chk("hb_en", 32'(bus.energyLvl), 32'h00FF);
        chk("hb_len", 32'(bus.pktLen), 32'h0);
        idle(2);

        // Type 1, LEN=3, alternating rx_valid gaps; also wraps past the top address.
        build(8'h01, 16'h1111, 16'h2222, 16'h3333, 8'd3, 1'b0);
        fr[8] = 8'hAA; fr[9] = 8'hBB; fr[10] = 8'hCC;
`ifdef PKT_CHECKSUM_EN
        fr[11] = fr[0] ^ fr[1] ^ fr[2] ^ fr[3] ^ fr[4] ^ fr[5] ^ fr[6] ^ fr[7] ^
                 fr[8] ^ fr[9] ^ fr[10];
`endif
        send_frame(1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("t2_len", 32'(bus.pktLen), 32'd3);
        chk("t2_type", 32'(bus.fPktType), 32'd1);
        idle(2);

        // LEN=4 address wrap, then LEN=MAX_PAYLOAD.
        build(8'h02, 16'h0102, 16'h0304, 16'h0506, 8'd4, 1'b0);
        send_frame(0);
        build(8'h03, 16'hBEEF, 16'hCAFE, 16'h7777, 8'(MAXP), 1'b0);
        send_frame(0);
        idle(1);

        // Drops: reserved type, oversize length; then a good frame.
        build(8'h07, 16'hDEAD, 16'hDEAD, 16'hDEAD, 8'd2, 1'b0);
        send_frame(0);
        build(8'h05, 16'hABCD, 16'hABCD, 16'hABCD, 8'(MAXP + 1), 1'b0);
        send_frame(2);
        build(8'hF9, 16'h4242, 16'h4343, 16'h4444, 8'd1, 1'b0);
        send_frame(0);
        idle(2);

`ifdef PKT_CHECKSUM_EN
        build(8'h04, 16'h1010, 16'h2020, 16'h3030, 8'd5, 1'b0);
        send_frame(0);
        build(8'h04, 16'h1010, 16'h2020, 16'h3030, 8'd5, 1'b1);
        send_frame(0);
        idle(2);
`endif

        // Reset mid-frame after SRC_L.
        build(8'h01, 16'h5555, 16'h6666, 16'h7777, 8'd5, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(fr[i], 1'b0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst1");
        hold_t = 3'b111; hold_s = '0; hold_d = '0; hold_e = '0; hold_l = '0;
        nrst = 1'b1;
        build(8'h06, 16'h9876, 16'h5432, 16'h1357, 8'd6, 1'b0);
        send_frame(0);
        idle(1);

        // Randomised frames, back-to-back or with idle gaps.
        for (int n = 0; n < 40; n++) begin
            tb_ = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0) len = 8'd0;
            else if (r == 1) len = 8'(MAXP);
            else if (r == 2) len = 8'(MAXP + 1 + $urandom_range(0, 10));
            else len = 8'($urandom_range(1, MAXP - 1));
            build(tb_, 16'($urandom), 16'($urandom), 16'($urandom), len,
                  ($urandom_range(0, 3) == 0));
            send_frame($urandom_range(0, 2));
            idle($urandom_range(0, 2));
        end

        idle(10);
        chk("evq_drained", 32'(evq.size()), 32'd0);
        chk("wrq_drained", 32'(wrq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
